ram_sdp_be_init: RTL and testbench
==================================

Name: ram_sdp_be_init

Overview:
- Single-clock simple-dual-port RAM for the leaf interface; successor to the fixed 16x128 dual-clock RAM with hard-coded initial contents.
- Adds byte-write enables, selectable read latency, defined read/write collision policy and a run-time init FSM that fills the array with a parameter value.
- Sits between leaf packet logic and local storage; one write port, one read port, both on clk.

Parameters:
- DWIDTH, 32, data width in bits; must be a multiple of 8; NBYTES = DWIDTH/8.
- AWIDTH, 7, address width; DEPTH = 1<<AWIDTH.
- RAM_TYPE, "distributed", ram_style attribute passed to the array.
- RD_LATENCY, 1, read latency in cycles; legal values 1 or 2.
- WRITE_MODE, 0, same-cycle same-address collision policy: 0 = READ_FIRST, 1 = WRITE_FIRST.
- INIT_VALUE, 0, DWIDTH-bit word written to every address by the init sweep.
- INIT_ON_RESET, 1, 1 = sweep starts automatically when reset deasserts.

Ports:
- clk  in  1  single clock for both ports.
- reset  in  1  asynchronous, active-high reset.
- init_req  in  1  one-cycle pulse; starts a fill sweep when idle.
- init_busy  out  1  high while the sweep runs; writes and reads are ignored.
- wr_en  in  1  write strobe.
- wr_addr  in  AWIDTH  write address.
- wr_be  in  NBYTES  byte enables; bit i gates wr_data[8i+7:8i].
- wr_data  in  DWIDTH  write data.
- rd_en  in  1  read strobe.
- rd_addr  in  AWIDTH  read address.
- rd_data  out  DWIDTH  read data; holds its last value when no read completes.
- rd_valid  out  1  one-cycle pulse marking a completed read.

Behaviour:
- Reset (async assert): rd_data=0, rd_valid=0, pipeline valid bits cleared, sweep counter=0. init_busy=INIT_ON_RESET; FSM enters INIT if INIT_ON_RESET=1, otherwise IDLE. Array contents are not reset.
- FSM states:
  - IDLE: accepts port traffic; init_req=1 moves the FSM to INIT on the next edge, counter=0.
  - INIT: each cycle writes INIT_VALUE to mem[counter] with all bytes enabled, then counter+1. After writing address DEPTH-1 the FSM returns to IDLE. The sweep takes exactly DEPTH cycles with init_busy=1; init_busy falls on the edge after the last write.
- In INIT: wr_en, rd_en and init_req are ignored (dropped, not queued), rd_valid=0, and in-flight reads are flushed.
- Reset asserted mid-sweep aborts it; with INIT_ON_RESET=1 the sweep restarts from address 0.
- Write: on an edge with wr_en=1 in IDLE, mem[wr_addr] byte i is updated only where wr_be[i]=1. wr_be=0 means no change.
- Read latency:
  - RD_LATENCY=1: rd_en at edge t gives rd_data/rd_valid after edge t.
  - RD_LATENCY=2: the array output is registered once more, so rd_valid rises one cycle later. Back-to-back reads give one result per cycle.
- Collision (rd_en, wr_en, rd_addr==wr_addr in the same cycle):
  - READ_FIRST returns the old word.
  - WRITE_FIRST returns the old word with the enabled bytes replaced by wr_data (bypass mux).
  - A write in any later cycle never alters a read already issued.
- rd_data changes only when a read completes.
- No arithmetic beyond the AWIDTH-bit sweep counter; the counter does not wrap during a sweep.

Decomposition:
- Shared package ram_pkg:
  - WRITE_MODE constants READ_FIRST=0 and WRITE_FIRST=1.
  - FSM state encoding ST_IDLE and ST_INIT.
  - A function returning NBYTES from DWIDTH.
- Sub-module ram_sdp_array holds the bare array with the RAM_TYPE attribute, a byte-enabled write and a registered read, so it infers cleanly. The top level holds the FSM, write mux (sweep vs port), collision bypass and latency-2 stage.
- Elaboration check: DWIDTH%8==0 and RD_LATENCY in {1,2}.

Test Plan:
- DWIDTH=32, AWIDTH=4, INIT_VALUE=32'hA5A5A5A5; release reset. Required: init_busy high for 16 cycles, then reads of addresses 0..15 return A5A5A5A5 with rd_valid after 1 cycle.
- Write 32'h11223344 at addr 3 with be=4'hF, then 32'hAABBCCDD with be=4'b0101. Required: read of addr 3 returns 32'h11BB33DD.
- Same-cycle write of 32'hDEADBEEF (be=F) and read at addr 7 holding 0. Required: WRITE_MODE=0 returns 0; WRITE_MODE=1 returns DEADBEEF; the next read returns DEADBEEF in both modes.
- RD_LATENCY=2, reads of addresses 0,1,2 on consecutive cycles. Required: rd_valid is high for 3 consecutive cycles starting 2 cycles after the first rd_en, with data in order.
- Pulse init_req and assert wr_en to addr 5 during the sweep. Required: the write is dropped and addr 5 reads INIT_VALUE. Assert reset at sweep count 8. Required: the sweep restarts at 0 and takes a full 16 cycles.
- INIT_ON_RESET=0. Required: init_busy=0 immediately after reset; rd_data=0 and rd_valid=0 while reset is held, with rd_en=1 during reset.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared constants for the leaf simple-dual-port RAM: collision policy codes,
// sweep FSM encoding and the byte-lane count helper.
package ram_pkg;

    localparam int READ_FIRST  = 0;
    localparam int WRITE_FIRST = 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_INIT = 1'b1;

    function automatic int nbytes(input int dwidth);
        return dwidth / 8;
    endfunction

endpackage

// File: rtl/ram_sdp_array.sv
// Bare byte-enabled storage with one registered read; read-first on collision.
// One-cycle read latency, no backpressure: the output register loads only when re is high.
module ram_sdp_array #(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 7,
    parameter int NBYTES   = 4,
    parameter     RAM_TYPE = "distributed"
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [NBYTES-1:0] wbe,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              re,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0] rdata
);

    (* ram_style = RAM_TYPE *) logic [DWIDTH-1:0] mem [0:(1<<AWIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (wbe[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Only the output register is reset; the array itself keeps its contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ram_sdp_be_init.sv
// Single-clock SDP RAM with byte enables, 1/2-cycle read latency, collision policy and fill sweep.
// No backpressure: port traffic arriving while the sweep runs is dropped, in-flight reads flushed.
module ram_sdp_be_init
    import ram_pkg::*;
#(
    parameter int               DWIDTH        = 32,
    parameter int               AWIDTH        = 7,
    parameter                   RAM_TYPE      = "distributed",
    parameter int               RD_LATENCY    = 1,
    parameter int               WRITE_MODE    = 0,
    parameter logic [DWIDTH-1:0] INIT_VALUE   = '0,
    parameter int               INIT_ON_RESET = 1,
    localparam int              NBYTES        = nbytes(DWIDTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init_req,
    output logic              init_busy,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [NBYTES-1:0] wr_be,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [DWIDTH-1:0] rd_data,
    output logic              rd_valid
);

    generate
        if ((DWIDTH % 8) != 0 || (RD_LATENCY != 1 && RD_LATENCY != 2)) begin : g_bad_cfg
            $error("ram_sdp_be_init: DWIDTH must be a multiple of 8 and RD_LATENCY 1 or 2");
        end
    endgenerate

    logic [0:0]        state;
    logic [AWIDTH-1:0] cnt;
    logic              busy;
    logic              flush;
    logic              rd_acc;

    assign busy      = (state == ST_INIT);
    assign init_busy = busy;
    // A read arriving with init_req would be flushed anyway, so it is never launched.
    assign flush     = busy | init_req;
    assign rd_acc    = rd_en & ~flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= (INIT_ON_RESET != 0) ? ST_INIT : ST_IDLE;
            cnt   <= '0;
        end else if (busy) begin
            cnt <= cnt + 1'b1;
            if (&cnt) begin
                state <= ST_IDLE;
            end
        end else if (init_req) begin
            state <= ST_INIT;
            cnt   <= '0;
        end
    end

    logic              arr_we;
    logic [AWIDTH-1:0] arr_waddr;
    logic [NBYTES-1:0] arr_be;
    logic [DWIDTH-1:0] arr_wdata;
    logic [DWIDTH-1:0] arr_q;

    assign arr_we    = ~reset & (busy | wr_en);
    assign arr_waddr = busy ? cnt : wr_addr;
    assign arr_be    = busy ? {NBYTES{1'b1}} : wr_be;
    assign arr_wdata = busy ? INIT_VALUE : wr_data;

    ram_sdp_array #(
        .DWIDTH   (DWIDTH),
        .AWIDTH   (AWIDTH),
        .NBYTES   (NBYTES),
        .RAM_TYPE (RAM_TYPE)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wbe   (arr_be),
        .wdata (arr_wdata),
        .re    (rd_acc),
        .raddr (rd_addr),
        .rdata (arr_q)
    );

    // The array is read-first; write-first is built by patching the old word after the edge.
    logic              byp_hit;
    logic [NBYTES-1:0] byp_be;
    logic [DWIDTH-1:0] byp_data;
    logic              v1;
    logic [DWIDTH-1:0] s1_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byp_hit  <= 1'b0;
            byp_be   <= '0;
            byp_data <= '0;
            v1       <= 1'b0;
        end else begin
            v1 <= rd_acc;
            if (rd_acc) begin
                byp_hit  <= (WRITE_MODE == WRITE_FIRST) && wr_en && (wr_addr == rd_addr);
                byp_be   <= wr_be;
                byp_data <= wr_data;
            end
        end
    end

    always_comb begin
        s1_data = arr_q;
        for (int i = 0; i < NBYTES; i++) begin
            if (byp_hit && byp_be[i]) begin
                s1_data[8*i +: 8] = byp_data[8*i +: 8];
            end
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic              v2;
            logic [DWIDTH-1:0] d2;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    v2 <= 1'b0;
                    d2 <= '0;
                end else begin
                    v2 <= v1 & ~flush;
                    if (v1 && !flush) begin
                        d2 <= s1_data;
                    end
                end
            end

            assign rd_valid = v2;
            assign rd_data  = d2;
        end else begin : g_lat1
            assign rd_valid = v1;
            assign rd_data  = s1_data;
        end
    endgenerate

endmodule

// File: tb/tb_ram_sdp_be_init.sv
// Bench for ram_sdp_be_init: directed table, hand sequences and randomized traffic vs a word-level model.
// Instance a: latency 1 / read-first, b: latency 2 / write-first, c: no init on reset.
module tb_ram_sdp_be_init;

    localparam logic [31:0] IV = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rst, c_rst;
    logic        init_req, wr_en, rd_en, c_rd_en;
    logic [3:0]  wr_addr, rd_addr, wr_be;
    logic [31:0] wr_data;
    logic        a_busy, b_busy, c_busy, a_valid, b_valid, c_valid;
    logic [31:0] a_data, b_data, c_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ram_sdp_be_init #(.DWIDTH(32), .AWIDTH(4), .RD_LATENCY(1), .WRITE_MODE(0),
                      .INIT_VALUE(IV), .INIT_ON_RESET(1)) dut_a (
        .clk(clk), .reset(rst), .init_req(init_req), .init_busy(a_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_data), .rd_valid(a_valid));

    ram_sdp_be_init #(.DWIDTH(32), .AWIDTH(4), .RD_LATENCY(2), .WRITE_MODE(1),
                      .INIT_VALUE(IV), .INIT_ON_RESET(1)) dut_b (
        .clk(clk), .reset(rst), .init_req(init_req), .init_busy(b_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_data), .rd_valid(b_valid));

    ram_sdp_be_init #(.DWIDTH(32), .AWIDTH(4), .RD_LATENCY(1), .WRITE_MODE(0),
                      .INIT_VALUE(IV), .INIT_ON_RESET(0)) dut_c (
        .clk(clk), .reset(c_rst), .init_req(1'b0), .init_busy(c_busy),
        .wr_en(1'b0), .wr_addr(4'd0), .wr_be(4'd0), .wr_data(32'd0),
        .rd_en(c_rd_en), .rd_addr(4'd0), .rd_data(c_data), .rd_valid(c_valid));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Word-level reference: a plain array, a count of sweep words left, and the
    // results each port is expected to show, with b's view delayed one more cycle.
    logic [31:0] m_mem [16];
    int          sweep_left = 0;
    bit          m_on = 0;
    bit          ea_v = 0, eb_v1 = 0, eb_v2 = 0;
    logic [31:0] ea_d = '0, eb_d1 = '0, eb_d2 = '0;

    always @(posedge clk) begin
        logic [31:0] old, wf;
        if (rst) begin
            m_on = 1; sweep_left = 16;
            ea_v = 0; ea_d = '0; eb_v1 = 0; eb_v2 = 0; eb_d2 = '0;
        end else if (m_on && sweep_left > 0) begin
            m_mem[16 - sweep_left] = IV;
            sweep_left--;
            ea_v = 0; eb_v1 = 0; eb_v2 = 0;
        end else if (m_on) begin
            old = m_mem[rd_addr];
            wf  = old;
            if (wr_en && wr_addr == rd_addr)
                for (int k = 0; k < 4; k++) if (wr_be[k]) wf[8*k +: 8] = wr_data[8*k +: 8];
            if (init_req) begin
                ea_v = 0; eb_v1 = 0; eb_v2 = 0;
                sweep_left = 16;
            end else begin
                eb_v2 = eb_v1;
                if (eb_v1) eb_d2 = eb_d1;
                eb_v1 = rd_en;
                if (rd_en) eb_d1 = wf;
                ea_v = rd_en;
                if (rd_en) ea_d = old;
            end
            if (wr_en)
                for (int k = 0; k < 4; k++) if (wr_be[k]) m_mem[wr_addr][8*k +: 8] = wr_data[8*k +: 8];
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("a_busy",  32'(a_busy),  32'(sweep_left > 0));
            chk("b_busy",  32'(b_busy),  32'(sweep_left > 0));
            chk("a_valid", 32'(a_valid), 32'(ea_v));
            chk("a_data",  a_data, ea_d);
            chk("b_valid", 32'(b_valid), 32'(eb_v2));
            chk("b_data",  b_data, eb_d2);
        end
    end

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        re;
        logic [3:0]  ra;
        logic        av;
        logic [31:0] ad;
        logic        bv;
        logic [31:0] bd;
    } vec_t;

    vec_t tbl [13];
    int   n;

    initial begin
        tbl[0]  = '{1'b1, 4'd0, 4'hF, 32'h10,       1'b0, 4'd0, 1'b0, IV,           1'b0, IV};
        tbl[1]  = '{1'b1, 4'd1, 4'hF, 32'h11,       1'b0, 4'd0, 1'b0, IV,           1'b0, IV};
        tbl[2]  = '{1'b1, 4'd2, 4'hF, 32'h12,       1'b0, 4'd0, 1'b0, IV,           1'b0, IV};
        tbl[3]  = '{1'b1, 4'd3, 4'hF, 32'h11223344, 1'b1, 4'd0, 1'b1, 32'h10,       1'b0, IV};
        tbl[4]  = '{1'b1, 4'd3, 4'h5, 32'hAABBCCDD, 1'b0, 4'd0, 1'b0, 32'h10,       1'b1, 32'h10};
        tbl[5]  = '{1'b1, 4'd7, 4'hF, 32'h0,        1'b1, 4'd3, 1'b1, 32'h11BB33DD, 1'b0, 32'h10};
        tbl[6]  = '{1'b1, 4'd7, 4'hF, 32'hDEADBEEF, 1'b1, 4'd7, 1'b1, 32'h0,        1'b1, 32'h11BB33DD};
        tbl[7]  = '{1'b0, 4'd0, 4'h0, 32'h0,        1'b1, 4'd7, 1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
        tbl[8]  = '{1'b0, 4'd0, 4'h0, 32'h0,        1'b1, 4'd0, 1'b1, 32'h10,       1'b1, 32'hDEADBEEF};
        tbl[9]  = '{1'b0, 4'd0, 4'h0, 32'h0,        1'b1, 4'd1, 1'b1, 32'h11,       1'b1, 32'h10};
        tbl[10] = '{1'b0, 4'd0, 4'h0, 32'h0,        1'b1, 4'd2, 1'b1, 32'h12,       1'b1, 32'h11};
        tbl[11] = '{1'b0, 4'd0, 4'h0, 32'h0,        1'b0, 4'd0, 1'b0, 32'h12,       1'b1, 32'h12};
        tbl[12] = '{1'b0, 4'd0, 4'h0, 32'h0,        1'b0, 4'd0, 1'b0, 32'h12,       1'b0, 32'h12};

        rst = 1; c_rst = 1; init_req = 0; wr_en = 0; rd_en = 1; c_rd_en = 1;
        wr_addr = 0; rd_addr = 0; wr_be = 0; wr_data = 0;
        tick(); tick();
        chk("rst_a_valid", 32'(a_valid), 32'd0);
        chk("rst_a_data",  a_data, 32'd0);
        chk("rst_a_busy",  32'(a_busy), 32'd1);
        chk("rst_b_data",  b_data, 32'd0);
        chk("rst_c_busy",  32'(c_busy), 32'd0);
        chk("rst_c_valid", 32'(c_valid), 32'd0);
        chk("rst_c_data",  c_data, 32'd0);
        rd_en = 0; rst = 0; c_rst = 0; c_rd_en = 0;

        n = 0;
        while (a_busy && n < 40) begin n++; tick(); end
        chk("sweep_len", 32'(n), 32'd16);
        chk("c_busy_after_rst", 32'(c_busy), 32'd0);

        for (int i = 0; i < 16; i++) begin
            rd_en = 1; rd_addr = 4'(i);
            tick();
            chk("init_rd_valid", 32'(a_valid), 32'd1);
            chk("init_rd_data",  a_data, IV);
        end
        rd_en = 0;
        tick(); tick();

        for (int i = 0; i < 13; i++) begin
            wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_be = tbl[i].be; wr_data = tbl[i].wd;
            rd_en = tbl[i].re; rd_addr = tbl[i].ra;
            tick();
            chk("tbl_a_valid", 32'(a_valid), 32'(tbl[i].av));
            chk("tbl_a_data",  a_data, tbl[i].ad);
            chk("tbl_b_valid", 32'(b_valid), 32'(tbl[i].bv));
            chk("tbl_b_data",  b_data, tbl[i].bd);
        end
        wr_en = 0; rd_en = 0;
        tick();

        // A write to an already-swept address mid-sweep must be dropped.
        init_req = 1; tick(); init_req = 0;
        repeat (8) tick();
        wr_en = 1; wr_addr = 5; wr_be = 4'hF; wr_data = 32'h0; rd_en = 1; rd_addr = 5;
        tick();
        chk("drop_busy",  32'(a_busy), 32'd1);
        chk("drop_valid", 32'(a_valid), 32'd0);
        wr_en = 0; rd_en = 0;
        n = 0;
        while (a_busy && n < 40) begin n++; tick(); end
        chk("drop_sweep_done", 32'(a_busy), 32'd0);
        rd_en = 1; rd_addr = 5; tick(); rd_en = 0;
        chk("drop_rd_data", a_data, IV);

        // Reset at sweep count 8 restarts a full sweep.
        wr_en = 1; wr_addr = 12; wr_be = 4'hF; wr_data = 32'h0C0C0C0C; tick(); wr_en = 0;
        init_req = 1; tick(); init_req = 0;
        repeat (8) tick();
        rst = 1; tick();
        chk("midrst_busy", 32'(a_busy), 32'd1);
        rst = 0;
        n = 0;
        while (a_busy && n < 40) begin n++; tick(); end
        chk("restart_len", 32'(n), 32'd16);
        rd_en = 1; rd_addr = 12; tick();
        chk("restart_rd12", a_data, IV);
        rd_en = 0; tick();

        for (int i = 0; i < 1500; i++) begin
            wr_en    = 1'($urandom_range(0, 1));
            wr_addr  = 4'($urandom_range(0, 15));
            wr_be    = 4'($urandom_range(0, 15));
            wr_data  = $urandom;
            rd_en    = 1'($urandom_range(0, 1));
            rd_addr  = ($urandom_range(0, 2) == 0) ? wr_addr : 4'($urandom_range(0, 15));
            init_req = ($urandom_range(0, 299) == 0);
            tick();
        end
        wr_en = 0; rd_en = 0; init_req = 0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
